// File: rtl/pixel_stream_source.sv
// Raster-order pixel source: 1-cycle-latency ROM reads feed a 2-entry skid buffer behind a valid/ready stream.
// Optional BORDER_PAD_EN adds one PAD_VALUE row above and below the image.
module pixel_stream_source #(
   parameter int         W         = 224,
   parameter int         H         = 224,
   parameter int         AW        = 16,
   parameter logic [7:0] PAD_VALUE = 8'b1110_0000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   output logic          mem_rd_en_o,
   output logic [AW-1:0] mem_addr_o,
   input  logic [7:0]    mem_data_i,
   output logic [7:0]    pix_data_o,
   output logic          pix_valid_o,
   input  logic          pix_ready_i,
   output logic          pix_sof_o,
   output logic          pix_eol_o,
   output logic          busy_o,
   output logic          finished_o
);

   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H + 2);
   localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(W * H - 1);
`ifdef BORDER_PAD_EN
   localparam logic [RW-1:0] ROW_IMG_LAST = RW'(H);
`else
   localparam logic [RW-1:0] ROW_IMG_LAST = RW'(H - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_DONE
`ifdef BORDER_PAD_EN
      , S_PAD_TOP
      , S_PAD_BOT
`endif
   } state_t;

   state_t        state_q;
   logic [AW-1:0] addr_q;
   logic          all_rd_q;
   logic          inflight_q;
   logic [1:0]    cnt_q;
   logic [7:0]    buf_q [2];
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;

   logic       xfer, pop, issue, col_last, last_img, pad_st, wr_slot;
   logic [1:0] cnt_d;

`ifdef BORDER_PAD_EN
   assign pad_st = (state_q == S_PAD_TOP) | (state_q == S_PAD_BOT);
`else
   assign pad_st = 1'b0;
`endif

   assign pix_valid_o = pad_st | ((state_q == S_STREAM) & (cnt_q != 2'd0));
   assign pix_data_o  = pad_st ? PAD_VALUE : (pix_valid_o ? buf_q[0] : 8'h00);
   assign col_last    = (col_q == COL_LAST);
   assign pix_eol_o   = pix_valid_o & col_last;
   assign pix_sof_o   = pix_valid_o & (col_q == '0) & (row_q == '0);
   assign busy_o      = (state_q != S_IDLE) & (state_q != S_DONE);
   assign finished_o  = (state_q == S_DONE);
   assign mem_rd_en_o = issue;
   assign mem_addr_o  = addr_q;

   // Occupancy after this cycle's pop plus the read landing now; a new read
   // is allowed only if that leaves room, so the buffer can never exceed 2.
   always_comb begin
      xfer     = pix_valid_o & pix_ready_i;
      pop      = xfer & (state_q == S_STREAM);
      cnt_d    = cnt_q - {1'b0, pop} + {1'b0, inflight_q};
      issue    = (state_q == S_STREAM) & ~all_rd_q & (cnt_d < 2'd2) & ~rst_i;
      wr_slot  = (cnt_q == 2'd2) | ((cnt_q == 2'd1) & ~pop);
      last_img = pop & col_last & (row_q == ROW_IMG_LAST);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         all_rd_q   <= 1'b0;
         inflight_q <= 1'b0;
         cnt_q      <= 2'd0;
         buf_q[0]   <= 8'h00;
         buf_q[1]   <= 8'h00;
         col_q      <= '0;
         row_q      <= '0;
      end else begin
         inflight_q <= issue;
         cnt_q      <= cnt_d;
         if (issue) begin
            if (addr_q == ADDR_LAST) all_rd_q <= 1'b1;
            else                     addr_q   <= addr_q + AW'(1);
         end
         if (pop)        buf_q[0]       <= buf_q[1];
         if (inflight_q) buf_q[wr_slot] <= mem_data_i;
         if (xfer) begin
            if (col_last) begin
               col_q <= '0;
               row_q <= row_q + RW'(1);
            end else begin
               col_q <= col_q + CW'(1);
            end
         end
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
`ifdef BORDER_PAD_EN
                  state_q <= S_PAD_TOP;
`else
                  state_q <= S_STREAM;
`endif
                  addr_q   <= '0;
                  all_rd_q <= 1'b0;
                  col_q    <= '0;
                  row_q    <= '0;
               end
            end
            S_STREAM: begin
               if (last_img) begin
`ifdef BORDER_PAD_EN
                  state_q <= S_PAD_BOT;
`else
                  state_q <= S_DONE;
`endif
               end
            end
`ifdef BORDER_PAD_EN
            S_PAD_TOP: if (xfer & col_last) state_q <= S_STREAM;
            S_PAD_BOT: if (xfer & col_last) state_q <= S_DONE;
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source at W=4, H=3 with a ROM holding ROM[i]=i.
module tb_pixel_stream_source;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int AW   = 16;
   localparam int NIMG = W * H;
`ifdef BORDER_PAD_EN
   localparam int NPIX = (H + 2) * W;
`else
   localparam int NPIX = W * H;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          ready = 1'b1;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_data = 8'h00;
   logic [7:0]    pix_data;
   logic          pix_valid, pix_sof, pix_eol, busy, finished;

   pixel_stream_source #(.W(W), .H(H), .AW(AW), .PAD_VALUE(8'hE0)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .mem_rd_en_o (mem_rd_en),
      .mem_addr_o  (mem_addr),
      .mem_data_i  (mem_data),
      .pix_data_o  (pix_data),
      .pix_valid_o (pix_valid),
      .pix_ready_i (ready),
      .pix_sof_o   (pix_sof),
      .pix_eol_o   (pix_eol),
      .busy_o      (busy),
      .finished_o  (finished)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd_en) mem_data <= mem_addr[7:0];

   logic [9:0] exp_px [NPIX];   // {sof, eol, data}
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // mode 0: ready always 1; mode 1: ready 1,0,1,0...; mode 2: ready 0 for 10 cycles
   task automatic run_frame(input int mode, input int glitch_cyc, input int abort_n);
      int idx = 0, cyc = 0, first_v = -1, nrd = 0, maxa = 0;
      bit stall = 1'b0, done = 1'b0, aborted = 1'b0;
      logic [7:0] hold_d = 8'h00;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; cyc = 1;
      #1;
      chk("busy_on", busy, 1);
      chk("fin_clr", finished, 0);
      while (!done && cyc < 200) begin
         case (mode)
            1:       ready = (cyc % 2) == 1;
            2:       ready = cyc > 10;
            default: ready = 1'b1;
         endcase
         start = (cyc == glitch_cyc);
         #1;
         if (mem_rd_en) begin
            nrd++;
            if (int'(mem_addr) > maxa) maxa = int'(mem_addr);
         end
         if (mode == 2 && cyc == 10) chk("stall_reads", nrd <= 2, 1);
         if (stall) chk("hold", {pix_valid, pix_data}, {1'b1, hold_d});
         if (pix_valid && first_v < 0) first_v = cyc;
         if (pix_valid && ready) begin
            chk("px", {pix_sof, pix_eol, pix_data}, exp_px[idx]);
            idx++;
            if (idx == abort_n) begin done = 1'b1; aborted = 1'b1; end
            if (idx == NPIX) done = 1'b1;
         end
         stall  = pix_valid & ~ready;
         hold_d = pix_data;
         @(negedge clk); cyc++;
      end
      start = 1'b0;
      if (!done) chk("timeout", idx, NPIX);
      if (done && !aborted) begin
         #1;
         chk("fin_set", finished, 1);
         chk("busy_off", busy, 0);
         chk("valid_off", pix_valid, 0);
         repeat (3) begin
            @(negedge clk); #1;
            if (mem_rd_en) nrd++;
            chk("done_quiet", {pix_valid, finished}, 2'b01);
         end
         chk("nreads", nrd, NIMG);
         chk("max_addr", maxa, NIMG - 1);
`ifndef BORDER_PAD_EN
         // start sampled at cycle-0 edge; data lands two edges later
         if (mode == 0) chk("latency", first_v, 3);
`endif
      end
   endtask

   initial begin
      for (int k = 0; k < NPIX; k++) begin
`ifdef BORDER_PAD_EN
         if (k < W || k >= NPIX - W) exp_px[k] = {k == 0, (k % W) == W - 1, 8'hE0};
         else                        exp_px[k] = {1'b0, (k % W) == W - 1, 8'(k - W)};
`else
         exp_px[k] = {k == 0, (k % W) == W - 1, 8'(k)};
`endif
      end

      repeat (2) @(negedge clk);
      #1;
      chk("rst_outs", {mem_rd_en, mem_addr, pix_data, pix_valid, pix_sof, pix_eol, busy, finished}, 0);
      rst = 1'b0;

      // start and rst together: rst wins
      @(negedge clk); rst = 1'b1; start = 1'b1;
      @(negedge clk); rst = 1'b0; start = 1'b0;
      @(negedge clk); #1;
      chk("rst_wins", {busy, pix_valid, mem_rd_en}, 0);

      run_frame(0, -1, -1);
      run_frame(1, -1, -1);
      run_frame(2, -1, -1);

      // reset mid-frame
      run_frame(0, -1, 5);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("rst_mid", {pix_valid, busy, finished, mem_rd_en}, 0);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk); #1;
         chk("rst_idle", {pix_valid, busy}, 0);
      end
      run_frame(0, -1, -1);

      // start during streaming is ignored, then restart from DONE
      run_frame(0, 6, -1);
      run_frame(1, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
